isp_loader_ctrl: RTL and testbench
==================================

Name: isp_loader_ctrl

Overview:
- In-system-programming controller between the SoC UART byte stream and the shared instruction/data memory write port.
- Parses a byte-oriented command protocol and issues word writes to memory.
- Holds the CPU in reset while loading and returns ACK/NAK bytes to the UART transmitter.
- Instantiated in soc_top between the UART RX/TX cores (isp_uart_rx/isp_uart_tx path) and the memory arbiter.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum clk cycles allowed between bytes of a multi-byte command before it is aborted.
- BOOT_HOLD, 1: if 1, cpu_rst_n is held low out of reset until a 'G' command; if 0, the CPU is released at reset deassertion.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received UART byte.
- tx_valid  output  1  response byte valid; held until accepted.
- tx_data  output  8  response byte.
- tx_ready  input  1  UART TX accepts the byte when tx_valid && tx_ready.
- mem_req  output  1  write request; held until granted.
- mem_addr  output  32  word-aligned byte address.
- mem_wdata  output  32  write data.
- mem_be  output  4  byte enables; always 4'hF when mem_req=1.
- mem_gnt  input  1  write accepted when mem_req && mem_gnt.
- cpu_rst_n  output  1  active-low CPU reset.
- rx_drop  output  1  one-cycle pulse: a received byte was discarded.

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, rx_drop=0.
  - cpu_rst_n = ~BOOT_HOLD.
  - State IDLE; timeout counter 0.
- Commands (first byte):
  - 0x57 'W': 4 address bytes, then 4 data bytes, both little-endian (first byte = bits 7:0).
  - 0x48 'H': cpu_rst_n<=0.
  - 0x47 'G': cpu_rst_n<=1.
  - Any other byte: NAK.
- Responses: ACK=0x06, NAK=0x15.
- States:
  - IDLE: on rx_valid decode the byte.
    - 'W' -> ADDR, byte index 0.
    - 'H' or 'G' -> apply the cpu_rst_n change in the same cycle as the byte, then RESP with ACK.
    - Unknown -> RESP with NAK.
  - ADDR: shift in address bytes; after the 4th byte go to DATA.
  - DATA: shift in data bytes. On the 4th byte:
    - if addr[1:0]!=0 -> RESP with NAK; no memory write.
    - else -> MEM.
  - MEM: mem_req=1 from the first MEM cycle; addr/wdata stable. On mem_gnt, drop mem_req the next cycle -> RESP with ACK.
  - RESP: tx_valid=1 with tx_data stable. On tx_ready -> IDLE; tx_valid=0 the following cycle.
- Latency:
  - 'H'/'G': tx_valid rises 1 cycle after the command byte's rx_valid.
  - 'W': mem_req rises 1 cycle after the 8th payload byte; ACK rises 1 cycle after the grant cycle.
- Dropped bytes: rx_valid in MEM or RESP discards the byte and pulses rx_drop the next cycle; state is unchanged.
- Timeout:
  - Counter clears on every accepted byte and counts every cycle in ADDR/DATA.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, no response, partial data discarded.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Simultaneous events:
  - Timeout expiry and rx_valid in the same cycle: the byte wins and the counter clears.
  - mem_gnt and rx_valid in the same cycle in MEM: grant processed, byte dropped.
- 'W' while cpu_rst_n=1 is permitted; the write is not blocked.
- Async reset mid-command aborts everything immediately; all outputs return to their reset values, including cpu_rst_n=~BOOT_HOLD.

Decomposition:
- Package isp_pkg:
  - command constants CMD_WRITE=8'h57, CMD_HOLD=8'h48, CMD_GO=8'h47, RSP_ACK=8'h06, RSP_NAK=8'h15;
  - state enum isp_state_t {IDLE, ADDR, DATA, MEM, RESP}.
- One sub-module, isp_byte_shifter: 4-byte little-endian assembler with byte index and done flag, used for both address and data.

Test Plan:
- Reset with BOOT_HOLD=1 -> cpu_rst_n=0, mem_req=0, tx_valid=0. Send 0x47 -> cpu_rst_n=1, tx_data=0x06 one cycle later.
- Send 57 10 00 00 00 EF BE AD DE, grant after 3 cycles -> mem_addr=0x00000010, mem_wdata=0xDEADBEEF, mem_be=F, mem_req high exactly until grant, then ACK 0x06.
- Send 57 11 00 00 00 01 02 03 04 -> no mem_req, NAK 0x15.
- Send 0x3F -> NAK 0x15; hold tx_ready=0 for 10 cycles -> tx_valid and tx_data stay stable until the handshake.
- TIMEOUT_CYCLES=16: send 57 00 and then idle 20 cycles -> back in IDLE with no response. Next byte 0x48 -> ACK and cpu_rst_n=0.
- Send a byte during MEM with mem_gnt withheld -> rx_drop pulses once, write completes unchanged. Assert rst_n low mid-DATA -> all outputs at reset values.

Source files
------------

// File: rtl/isp_pkg.sv
// isp_pkg: protocol bytes and FSM states shared by the ISP loader.
package isp_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_HOLD  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, RESP} isp_state_t;
endpackage

// File: rtl/isp_loader_ctrl_if.sv
// isp_loader_ctrl_if: UART byte stream and memory write port of the ISP loader.
interface isp_loader_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  modport master (
    input  rx_valid, rx_data, tx_ready, mem_gnt,
    output tx_valid, tx_data, mem_req, mem_addr, mem_wdata, mem_be
  );
  modport slave (
    output rx_valid, rx_data, tx_ready, mem_gnt,
    input  tx_valid, tx_data, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/isp_byte_shifter.sv
// isp_byte_shifter: assembles 4 bytes little-endian; done flags the 4th byte.
module isp_byte_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        done
);
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  always_comb begin
    word_d = en ? {din, word_q[31:8]} : word_q;
    idx_d  = clr ? 2'd0 : en ? idx_q + 2'd1 : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end
  assign word = word_q;
  assign done = en && idx_q == 2'd3;
endmodule

// File: rtl/isp_loader_ctrl.sv
// isp_loader_ctrl: parses UART ISP commands into memory word writes, controls CPU reset,
// and answers each command with ACK/NAK.
module isp_loader_ctrl
  import isp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit BOOT_HOLD      = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  isp_loader_ctrl_if.master   bus,
  output logic                cpu_rst_n,
  output logic                rx_drop
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  isp_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        tx_valid_q, tx_valid_d, mem_req_q, mem_req_d;
  logic        cpu_rst_n_q, cpu_rst_n_d, rx_drop_q, rx_drop_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        sh_clr, addr_en, data_en, addr_done, data_done;
  logic        is_write, is_hold, is_go, ack;
  logic [31:0] addr_word, data_word;
  isp_byte_shifter u_addr (
    .clk(clk), .rst_n(rst_n), .clr(sh_clr), .en(addr_en),
    .din(bus.rx_data), .word(addr_word), .done(addr_done)
  );
  isp_byte_shifter u_data (
    .clk(clk), .rst_n(rst_n), .clr(sh_clr), .en(data_en),
    .din(bus.rx_data), .word(data_word), .done(data_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_req_q   <= 1'b0;
      cpu_rst_n_q <= !BOOT_HOLD;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      mem_req_q   <= mem_req_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rx_drop_q   <= rx_drop_d;
    end
  end
  assign is_write = state_q == IDLE && bus.rx_valid && bus.rx_data == CMD_WRITE;
  assign is_hold  = state_q == IDLE && bus.rx_valid && bus.rx_data == CMD_HOLD;
  assign is_go    = state_q == IDLE && bus.rx_valid && bus.rx_data == CMD_GO;
  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (bus.rx_valid) state_d = is_write ? ADDR : RESP;
      ADDR, DATA:
        if (bus.rx_valid)
          state_d = state_q == ADDR ? (addr_done ? DATA : ADDR)
                  : !data_done ? DATA : addr_word[1:0] != 2'b00 ? RESP : MEM;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      MEM:  if (bus.mem_gnt) state_d = RESP;
      RESP: if (bus.tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sh_clr      = is_write;
    addr_en     = state_q == ADDR && bus.rx_valid;
    data_en     = state_q == DATA && bus.rx_valid;
    ack         = state_q == MEM || is_hold || is_go;
    rx_drop_d   = bus.rx_valid && (state_q == MEM || state_q == RESP);
    mem_req_d   = state_d == MEM;
    tx_valid_d  = state_d == RESP;
    tx_data_d   = state_q != RESP && state_d == RESP ? (ack ? RSP_ACK : RSP_NAK) : tx_data_q;
    cpu_rst_n_d = is_hold ? 1'b0 : is_go ? 1'b1 : cpu_rst_n_q;
  end
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = addr_word;
  assign bus.mem_wdata = data_word;
  assign bus.mem_be    = {4{mem_req_q}};
  assign cpu_rst_n     = cpu_rst_n_q;
  assign rx_drop       = rx_drop_q;
endmodule

// File: tb/tb_isp_loader_ctrl.sv
// tb_isp_loader_ctrl: directed and randomized commands checked against a command-level model.
module tb_isp_loader_ctrl;
  import isp_pkg::*;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst_n, rx_drop;
  int checks = 0;
  int errors = 0;
  logic model_cpu = 1'b0;
  isp_loader_ctrl_if bus();
  isp_loader_ctrl #(.TIMEOUT_CYCLES(TO), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cpu_rst_n(cpu_rst_n), .rx_drop(rx_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, " mem_req"}, bus.mem_req, 0);
    chk({tag, " tx_valid"}, bus.tx_valid, 0);
    chk({tag, " tx_data"}, bus.tx_data, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, " mem_be"}, bus.mem_be, 0);
    chk({tag, " rx_drop"}, rx_drop, 0);
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic check_resp(input string tag, input logic [7:0] exp, input int rdy_dly);
    chk({tag, " tx_valid"}, bus.tx_valid, 1);
    chk({tag, " tx_data"}, bus.tx_data, exp);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk({tag, " tx_valid hold"}, bus.tx_valid, 1);
      chk({tag, " tx_data hold"}, bus.tx_data, exp);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk({tag, " tx_valid drop"}, bus.tx_valid, 0);
  endtask
  task automatic do_simple(input logic [7:0] b, input int rdy_dly);
    if (b == CMD_HOLD) model_cpu = 1'b0;
    if (b == CMD_GO) model_cpu = 1'b1;
    send_byte(b);
    chk("cmd cpu_rst_n", cpu_rst_n, model_cpu);
    check_resp("cmd", (b == CMD_HOLD || b == CMD_GO) ? RSP_ACK : RSP_NAK, rdy_dly);
  endtask
  // gap < 0 picks a random inter-byte gap that stays inside the timeout window
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int gap,
                          input int gnt_dly, input int rdy_dly, input bit drop);
    logic [7:0] q[$];
    q = {CMD_WRITE, a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
    foreach (q[i]) begin
      if (i > 0) repeat (gap < 0 ? $urandom_range(0, TO - 1) : gap) @(negedge clk);
      send_byte(q[i]);
    end
    if (a[1:0] == 2'b00) begin
      chk("W mem_req rise", bus.mem_req, 1);
      chk("W mem_addr", bus.mem_addr, a);
      chk("W mem_wdata", bus.mem_wdata, d);
      chk("W mem_be", bus.mem_be, 4'hF);
      chk("W no early tx", bus.tx_valid, 0);
      if (drop) begin
        send_byte(8'hA5);
        chk("drop pulse", rx_drop, 1);
        chk("drop mem_req", bus.mem_req, 1);
        chk("drop mem_addr", bus.mem_addr, a);
        chk("drop mem_wdata", bus.mem_wdata, d);
        @(negedge clk);
        chk("drop single", rx_drop, 0);
      end
      for (int i = 0; i < gnt_dly; i++) begin
        @(negedge clk);
        chk("W mem_req hold", bus.mem_req, 1);
      end
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      chk("W mem_req drop", bus.mem_req, 0);
      check_resp("W ack", RSP_ACK, rdy_dly);
    end else begin
      chk("W misaligned no req", bus.mem_req, 0);
      check_resp("W nak", RSP_NAK, rdy_dly);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, d;
    logic [7:0] b;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    bus.mem_gnt  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("post reset");
    do_simple(CMD_GO, 0);
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 0, 3, 0, 1'b0);
    do_write(32'h0000_0011, 32'h0403_0201, 0, 0, 0, 1'b0);
    do_simple(8'h3F, 10);
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    chk("timeout no tx", bus.tx_valid, 0);
    chk("timeout no req", bus.mem_req, 0);
    do_simple(CMD_HOLD, 0);
    do_write(32'h0000_0100, 32'h1234_5678, TO - 1, 0, 1, 1'b0);
    send_byte(CMD_WRITE);
    repeat (TO) @(negedge clk);
    do_simple(CMD_GO, 0);
    do_write(32'h0000_0200, 32'hCAFE_F00D, 0, 4, 0, 1'b1);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          a = $urandom;
          d = $urandom;
          if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
          else a[1:0] = 2'b00;
          do_write(a, d, -1, $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
        2: do_simple(CMD_HOLD, $urandom_range(0, 4));
        3: do_simple(CMD_GO, $urandom_range(0, 4));
        default: begin
          do b = 8'($urandom); while (b == CMD_WRITE || b == CMD_HOLD || b == CMD_GO);
          do_simple(b, $urandom_range(0, 4));
        end
      endcase
    end
    do_simple(CMD_GO, 0);
    send_byte(CMD_WRITE);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    rst_n = 1'b0;
    #1;
    chk_reset("mid-DATA reset");
    model_cpu = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_simple(CMD_GO, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
